xpb_accum_ctrl: RTL

// - Sequencer that shares one xpb lookup port across NUM_DIGITS 5-bit digit positions of a reduction word.
// - Walks the digits one per cycle, driving table index + digit to the xpb ROM bank.
// - Accumulates each 1024-bit ROM response into a wide sum; hands the sum to the modular-square reducer via valid/ready.
// - Sits between the upper-word splitter and the final reduction adder tree.

---
 rtl/xpb_pkg.sv | 17 +
 rtl/xpb_accum_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/xpb_pkg.sv
// Shared sizing and FSM state encoding for the xpb lookup/accumulate path.
package xpb_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W    = 5;
   localparam int XPB_W      = 1024;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int ACC_W      = XPB_W + IDX_W;
   localparam int DIG_BUS_W  = NUM_DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/xpb_accum_ctrl.sv
// Walks NUM_DIGITS digits through one shared xpb ROM port, one per cycle,
// and sums the responses into a wide accumulator handed off via valid/ready.
module xpb_accum_ctrl
   import xpb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DIG_BUS_W-1:0] in_digits,
   output logic [IDX_W-1:0]     lut_sel,
   output logic [DIGIT_W-1:0]   lut_data_in,
   input  logic [XPB_W-1:0]     lut_data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_sum,
   output logic                 busy
);

   localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NUM_DIGITS - 1);

   state_e               state;
   logic [IDX_W-1:0]     step;
   logic [DIG_BUS_W-1:0] dig_sr;
   logic [ACC_W-1:0]     acc;

   // step and dig_sr are both zero outside RUN, so the ROM port stays quiet
   // without extra gating on these outputs.
   assign lut_sel     = step;
   assign lut_data_in = dig_sr[DIGIT_W-1:0];
   assign out_sum     = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         step      <= '0;
         dig_sr    <= '0;
         acc       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         step      <= '0;
         dig_sr    <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  dig_sr   <= in_digits;
                  acc      <= '0;
                  step     <= '0;
               end
            end
            RUN: begin
               // Zero digits still consume their cycle: latency is fixed.
               acc    <= acc + ACC_W'(lut_data_out);
               dig_sr <= dig_sr >> DIGIT_W;
               if (step == LAST_STEP) begin
                  step      <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  step <= step + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
